serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//  Bit-serial add controller. Time-shares one fullAdder cell (A,B,Cin -> S,Co) over WIDTH cycles,
//  LSB first. A carry flip-flop feeds Co back to Cin between bits.
//  Trades latency for area wherever a wide ripple adder is too large; start/done handshake to host.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range 2..32
// PORTS
//  clk    in   1      single clock, all state on rising edge
//  rst    in   1      synchronous, active-high reset
//  start  in   1      request; sampled only in IDLE
//  a      in   WIDTH  operand A, captured on accepted start
//  b      in   WIDTH  operand B, captured on accepted start
//  cin    in   1      carry-in, captured on accepted start
//  busy   out  1      high in RUN and DONE
//  done   out  1      one-cycle pulse, result valid
//  sum    out  WIDTH  result; held until next accepted start
//  cout   out  1      final carry-out; held with sum
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, sum=0, cout=0; bit counter=0, carry FF=0, shift regs=0.
//    Reset has priority over every other event, including in RUN/DONE; partial result is discarded.
//  - FSM states:
//      IDLE->RUN on start=1.
//      RUN->DONE when the bit counter reaches WIDTH-1 on the current edge.
//      DONE->IDLE unconditionally after one cycle.
//  - Accept edge E0 (IDLE, start=1):
//      load a and b into shift regs; carry FF<=cin; counter<=0; sum<=0, cout<=0.
//  - RUN edges E1..E_WIDTH, one bit per edge:
//      fullAdder inputs = shiftA[0], shiftB[0], carry FF.
//      S shifts into sum from the MSB side; carry FF<=Co; shiftA/shiftB shift right; counter++.
//  - After E_WIDTH: sum holds the full result, cout=carry FF, done=1 for exactly one cycle (DONE).
//  - Latency: done is high in the cycle following edge E_WIDTH, i.e. WIDTH+1 edges after the accept edge.
//    Minimum start-to-start spacing is WIDTH+2 cycles.
//  - start while busy=1 (RUN or DONE) is ignored: no queuing, no effect on the running operation.
//  - start held high continuously: a new operation is accepted on the first IDLE edge after DONE.
//  - a/b/cin changing after the accept edge: no effect on the result.
//  - Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
//  - sum/cout are stable during RUN only at the end; hosts read them only when done=1 or busy=0.
// CONFIGURATION
//  SERIAL_ADDER_SUB_EN defined:
//    - adds input port sub (1 bit), captured on the accept edge with the operands.
//    - sub=1: B is loaded bit-inverted and carry FF<=1 (cin ignored), giving sum=a-b.
//      cout=1 means no borrow (a>=b unsigned).
//    - sub=0: identical to plain add.
//  Not defined: no sub port; block is add-only; timing identical in both builds.
// TESTING
//  1. WIDTH=8; a=0x5A, b=0x33, cin=0, pulse start
//     -> busy next cycle; done 9 edges after accept; sum=0x8D, cout=0.
//  2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Separately a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
//  3. start pulsed again at accept+3 with a=0x01, b=0x01
//     -> ignored; first result unchanged; exactly one done pulse.
//  4. rst asserted at accept+4
//     -> next cycle busy=0, done=0, sum=0, cout=0.
//     Fresh start 0x10+0x20 then completes -> sum=0x30.
//  5. start held high across 3 operations -> each accept exactly WIDTH+2 cycles apart; one done per op.
//  6. SERIAL_ADDER_SUB_EN: sub=1, a=0x10, b=0x01 -> sum=0x0F, cout=1.
//     a=0x01, b=0x02 -> sum=0xFF, cout=0.
//  All scenarios: compare against a behavioural a+b+cin model, plus an exhaustive sweep at WIDTH=3.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial a+b+cin over WIDTH cycles (in clk,rst,start,a,b,cin[,sub]; out busy,done,sum,cout); SERIAL_ADDER_SUB_EN adds sub port for a-b
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [WIDTH-1:0] b_ld;
  logic             c_ld, s, co, accept, step, last;
`ifdef SERIAL_ADDER_SUB_EN
  assign b_ld = sub ? ~b : b;
  assign c_ld = sub | cin;
`else
  assign b_ld = b;
  assign c_ld = cin;
`endif
  assign s      = sa_q[0] ^ sb_q[0] ^ carry_q;
  assign co     = (sa_q[0] & sb_q[0]) | (carry_q & (sa_q[0] ^ sb_q[0]));
  assign accept = (state_q == IDLE) && start;
  assign step   = (state_q == RUN);
  assign last   = step && (cnt_q == LAST);
  always_comb begin
    state_d = accept ? RUN : step ? (last ? DONE : RUN) : IDLE;
    cnt_d   = accept ? '0 : step ? cnt_q + 1'b1 : cnt_q;
    sa_d    = accept ? a : step ? sa_q >> 1 : sa_q;
    sb_d    = accept ? b_ld : step ? sb_q >> 1 : sb_q;
    carry_d = accept ? c_ld : step ? co : carry_q;
    sum_d   = accept ? '0 : step ? {s, sum_q[WIDTH-1:1]} : sum_q;
    cout_d  = accept ? 1'b0 : last ? co : cout_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
  assign busy = (state_q == RUN) || (state_q == DONE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and random checks of serial_adder_ctrl against an arithmetic model
module tb_serial_adder_ctrl;
  localparam int W = 8;
  localparam int V = 3;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0, sub = 1'b0;
  logic [W-1:0] a = '0, b = '0, sum;
  logic busy, done, cout;
  logic start3 = 1'b0, cin3 = 1'b0, sub3 = 1'b0;
  logic [V-1:0] a3 = '0, b3 = '0, sum3;
  logic busy3, done3, cout3;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );
  serial_adder_ctrl #(.WIDTH(V)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .cin(cin3),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub3),
`endif
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
  );
  function automatic longint mdl(input longint x, input longint y, input logic c, input logic s, input int w);
    longint m = (longint'(1) << w) - 1;
    return (s ? x + (~y & m) + 1 : x + y + longint'(c)) & ((m << 1) | 1);
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run8(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic s, input int poke, input string tag);
    longint e = mdl(x, y, c, s, W);
    int lat = 0, nd = 0;
    logic [W:0] got = '0;
    a = x; b = y; cin = c; sub = s; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    chk({tag, " busy"}, 64'(busy), 64'd1);
    for (int k = 1; k <= W + 2; k++) begin
      if (done) begin
        nd++;
        if (lat == 0) begin lat = k; got = {cout, sum}; end
      end
      start = (k == poke);
      if (k == poke) begin a = 1; b = 1; end
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, " latency"}, 64'(lat), 64'(W + 1));
    chk({tag, " result"}, 64'(got), e);
    chk({tag, " done_pulses"}, 64'(nd), 64'd1);
    chk({tag, " idle_held"}, {62'd0, busy, done, sum, cout}, {62'd0, 2'b00, e[W-1:0], e[W]});
  endtask
  task automatic run3(input logic [V-1:0] x, input logic [V-1:0] y, input logic c, input logic s);
    longint e = mdl(x, y, c, s, V);
    int k = 0;
    a3 = x; b3 = y; cin3 = c; sub3 = s; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    while (!done3 && k < 2 * V + 4) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("w3 lat %0d_%0d_%0d_%0d", x, y, c, s), 64'(k), 64'(V));
    chk($sformatf("w3 res %0d_%0d_%0d_%0d", x, y, c, s), 64'({cout3, sum3}), e);
    @(negedge clk);
  endtask
  initial begin
    longint q[$];
    int acc, last_acc, nd;
    logic pb, s;
    repeat (2) @(negedge clk);
    chk("reset w8", {busy, done, sum, cout}, '0);
    chk("reset w3", {busy3, done3, sum3, cout3}, '0);
    rst = 1'b0;
    @(negedge clk);
    run8(8'h5A, 8'h33, 1'b0, 1'b0, 0, "t1");
    run8(8'hFF, 8'h01, 1'b0, 1'b0, 0, "t2a");
    run8(8'hFF, 8'hFF, 1'b1, 1'b0, 0, "t2b");
    run8(8'h5A, 8'h33, 1'b0, 1'b0, 3, "t3");
    a = 8'h77; b = 8'h66; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4 reset_mid", {busy, done, sum, cout}, '0);
    run8(8'h10, 8'h20, 1'b0, 1'b0, 0, "t4");
`ifdef SERIAL_ADDER_SUB_EN
    run8(8'h10, 8'h01, 1'b0, 1'b1, 0, "t6a");
    run8(8'h01, 8'h02, 1'b1, 1'b1, 0, "t6b");
`endif
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'b0; start = 1'b1;
    q.push_back(mdl(a, b, cin, 1'b0, W));
    acc = 0; last_acc = -1; nd = 0; pb = busy;
    for (int n = 1; n <= 3 * (W + 2) + 2; n++) begin
      @(negedge clk);
      if (busy && !pb) begin
        acc++;
        if (last_acc >= 0) chk("t5 spacing", 64'(n - last_acc), 64'(W + 2));
        last_acc = n;
        if (acc < 3) begin
          a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
          q.push_back(mdl(a, b, cin, 1'b0, W));
        end else start = 1'b0;
      end
      if (done) begin
        nd++;
        chk("t5 result", 64'({cout, sum}), q.size() > 0 ? q.pop_front() : -1);
      end
      pb = busy;
    end
    start = 1'b0;
    chk("t5 done_count", 64'(nd), 64'd3);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      run8(W'($urandom), W'($urandom), 1'($urandom), s, int'($urandom_range(0, W + 1)), $sformatf("rnd%0d", i));
    end
    for (int sv = 0; sv < 2; sv++) begin
`ifndef SERIAL_ADDER_SUB_EN
      if (sv == 1) break;
`endif
      for (int x = 0; x < (1 << V); x++)
        for (int y = 0; y < (1 << V); y++)
          for (int c = 0; c < 2; c++)
            run3(V'(x), V'(y), 1'(c), 1'(sv));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
